snake_ctrl: RTL and testbench
=============================

Name: snake_ctrl

Overview:
- Game-logic stage directly upstream of the VGA display top.
- Holds the snake body on a 40x30 grid of 16x16-pixel cells and advances it one cell per game tick.
- Tracks direction from key inputs, detects apple, wall and self collisions, and maintains game state.
- Classifies each scanned pixel (x_pos/y_pos from the display top) into the 2-bit snake code the display consumes; raises apple_eaten so the apple generator relocates.

Parameters:
- MAX_LEN, 16, maximum segments stored; length saturates here.
- STEP_CYCLES, 6250000, clk cycles per game tick (0.25 s at 25 MHz).
- INIT_X, 20, head cell x after reset/restart.
- INIT_Y, 15, head cell y after reset/restart.

Ports:
- clk  in  1  pixel-domain clock (25 MHz).
- rst  in  1  synchronous active-high reset.
- key_up / key_down / key_left / key_right  in  1 each  debounced direction requests, level or pulse.
- start  in  1  begin or restart game.
- x_pos  in  10  current pixel x from display.
- y_pos  in  10  current pixel y from display.
- apple_x  in  6  apple cell x (0..39).
- apple_y  in  5  apple cell y (0..29).
- snake  out  2  pixel code: 00 none, 01 head, 10 body, 11 wall.
- apple_eaten  out  1  one-cycle pulse when the head enters the apple cell.
- game_over  out  1  high while in DEAD.
- length  out  5  current segment count (3..MAX_LEN).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, dir=RIGHT, length=3.
  - seg0=(INIT_X,INIT_Y), seg1=(INIT_X-1,INIT_Y), seg2=(INIT_X-2,INIT_Y).
  - Tick counter=0; snake=00, apple_eaten=0, game_over=0.
- States:
  - IDLE: start -> PLAY.
  - PLAY: wall or self hit on a tick -> DEAD.
  - DEAD: start -> reinitialise exactly as reset, then go to PLAY.
- Tick counter:
  - Runs only in PLAY and wraps at STEP_CYCLES-1.
  - The wrap cycle is the step cycle; the counter is cleared on every state entry.
- Direction:
  - Key requests latch into pending_dir at any cycle.
  - Priority when several keys are high: up > down > left > right.
  - A request opposite to the current dir is ignored.
  - pending_dir is copied into dir only at a step cycle.
- Step cycle:
  - next_head = seg0 moved one cell in pending_dir.
  - Wall cells: x=0, x=39, y=0 or y=29.
  - Eat condition: next_head == (apple_x, apple_y).
  - Self hit: next_head equals any seg[i] for i in 0..length-2; also i = length-1 when eating.
  - Wall or self hit -> DEAD; segments are not updated.
  - Otherwise seg[i] <= seg[i-1] for i = 1..MAX_LEN-1, and seg0 <= next_head.
  - When eating: length <= min(length+1, MAX_LEN), and apple_eaten=1 on the following cycle only.
- Pixel classification (registered, latency 1 clk):
  - cx = x_pos[9:4], cy = y_pos[9:4].
  - Pixels outside the active area (x_pos >= 640 or y_pos >= 480) -> 00.
  - Wall cell -> 11.
  - Else cx,cy == seg0 -> 01.
  - Else matches seg[i] for 1 <= i < length -> 10.
  - Else -> 00.
  - Segments at index >= length never display.
  - Output is valid in every state, including IDLE and DEAD (frozen picture).
- game_over is a registered decode of state==DEAD.
- Simultaneous rst and start: rst wins.
- start while in PLAY: ignored.

Test Plan:
- Reset, no start, STEP_CYCLES=4 -> snake holds (20..18,15), length=3; pixel (320,240) -> snake=01 one cycle later; (304,240) -> 10; (0,0) -> 11; (700,10) -> 00.
- start, no keys, 3 ticks -> head at (23,15), tail at (21,15), game_over=0.
- apple at (22,15), start -> on the 2nd tick apple_eaten pulses exactly 1 cycle, length=4, seg3=(19,15).
- key_left while moving right -> ignored, head still advances +x; key_up then key_left within one tick -> up applied, head (20,14) after first tick.
- Run right from start -> head reaches x=38; next tick enters x=39 -> game_over=1, segments frozen; start -> state re-initialised, head (21,15) after one tick.
- Length 5, path down, left, up -> head hits own body -> DEAD; tail-chase with length 4 in a 2x2 loop -> no death (tail excluded when not eating).

Source files
------------

// File: rtl/snake_ctrl.sv
// Snake game logic: body storage, tick-paced movement, collision detection and
// per-pixel classification for the downstream VGA display.
module snake_ctrl #(
  parameter int MAX_LEN     = 16,
  parameter int STEP_CYCLES = 6250000,
  parameter int INIT_X      = 20,
  parameter int INIT_Y      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       start,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [5:0] apple_x,
  input  logic [4:0] apple_y,
  output logic [1:0] snake,
  output logic       apple_eaten,
  output logic       game_over,
  output logic [4:0] length
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, r_pend;
  logic [TW-1:0] r_tick;
  logic [5:0]    r_seg_x [MAX_LEN];
  logic [4:0]    r_seg_y [MAX_LEN];
  logic [4:0]    r_len;
  logic [1:0]    r_snake_p1;
  logic          r_eaten, r_game_over;

  logic       w_step, w_restart, w_req_vld, w_wall, w_eat, w_self, w_die, w_body;
  dir_t       w_req;
  logic [5:0] w_nh_x, w_cx, w_cy;
  logic [4:0] w_nh_y;
  logic [1:0] w_pix;

  assign w_step    = (r_state == S_PLAY) && (r_tick == TW'(STEP_CYCLES - 1));
  assign w_restart = (r_state == S_DEAD) && start;

  always_comb begin
    w_req_vld = 1'b1;
    w_req     = D_RIGHT;
    if (key_up)         w_req = D_UP;
    else if (key_down)  w_req = D_DOWN;
    else if (key_left)  w_req = D_LEFT;
    else if (key_right) w_req = D_RIGHT;
    else                w_req_vld = 1'b0;
  end

  // Candidate head and its collisions; the tail only counts when the snake grows
  always_comb begin
    w_nh_x = r_seg_x[0];
    w_nh_y = r_seg_y[0];
    case (r_pend)
      D_UP:    w_nh_y = r_seg_y[0] - 5'd1;
      D_DOWN:  w_nh_y = r_seg_y[0] + 5'd1;
      D_LEFT:  w_nh_x = r_seg_x[0] - 6'd1;
      default: w_nh_x = r_seg_x[0] + 6'd1;
    endcase
    w_wall = (w_nh_x == 6'd0) || (w_nh_x == 6'd39) || (w_nh_y == 5'd0) || (w_nh_y == 5'd29);
    w_eat  = (w_nh_x == apple_x) && (w_nh_y == apple_y);
    w_self = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((5'(i) < r_len - 5'd1) || (w_eat && (5'(i) == r_len - 5'd1))) &&
          (r_seg_x[i] == w_nh_x) && (r_seg_y[i] == w_nh_y))
        w_self = 1'b1;
    end
    w_die = w_wall || w_self;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_step && w_die) w_state_nxt = S_DEAD;
      S_DEAD:  if (start) w_state_nxt = S_PLAY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_eaten     <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_eaten     <= w_step && !w_die && w_eat;
      r_game_over <= (w_state_nxt == S_DEAD);
      if ((w_state_nxt != r_state) || (r_state != S_PLAY) || w_step) r_tick <= '0;
      else                                                            r_tick <= r_tick + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_dir  <= D_RIGHT;
      r_pend <= D_RIGHT;
      r_len  <= 5'd3;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= (i < 3) ? 6'(INIT_X - i) : 6'(INIT_X - 2);
        r_seg_y[i] <= 5'(INIT_Y);
      end
    end else begin
      if (w_req_vld && (w_req != opposite(r_dir))) r_pend <= w_req;
      if (w_step) r_dir <= r_pend;
      if (w_step && !w_die) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_nh_x;
        r_seg_y[0] <= w_nh_y;
        if (w_eat && (r_len < 5'(MAX_LEN))) r_len <= r_len + 5'd1;
      end
    end
  end

  assign w_cx = x_pos[9:4];
  assign w_cy = y_pos[9:4];

  always_comb begin
    w_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < r_len) && (r_seg_x[i] == w_cx) && ({1'b0, r_seg_y[i]} == w_cy))
        w_body = 1'b1;
    end
    w_pix = 2'b00;
    if ((x_pos < 10'd640) && (y_pos < 10'd480)) begin
      if ((w_cx == 6'd0) || (w_cx == 6'd39) || (w_cy == 6'd0) || (w_cy == 6'd29))
        w_pix = 2'b11;
      else if ((w_cx == r_seg_x[0]) && (w_cy == {1'b0, r_seg_y[0]}))
        w_pix = 2'b01;
      else if (w_body)
        w_pix = 2'b10;
    end
  end

  // Pixel stage p1: one-cycle classified output
  always_ff @(posedge clk) begin
    if (rst) r_snake_p1 <= 2'b00;
    else     r_snake_p1 <= w_pix;
  end

  assign snake       = r_snake_p1;
  assign apple_eaten = r_eaten;
  assign game_over   = r_game_over;
  assign length      = r_len;

endmodule

// File: tb/tb_snake_ctrl.sv
// Scoreboarded bench for snake_ctrl: a queue-based game model predicts every
// cycle's outputs; a monitor pops and compares one cycle after each edge.
module tb_snake_ctrl;
  localparam int STEP = 4;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst, key_up, key_down, key_left, key_right, start;
  logic [9:0] x_pos, y_pos;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic [1:0] snake;
  logic       apple_eaten, game_over;
  logic [4:0] length;

  always #5 clk = ~clk;

  snake_ctrl #(.MAX_LEN(MAXL), .STEP_CYCLES(STEP), .INIT_X(20), .INIT_Y(15)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .start(start), .x_pos(x_pos), .y_pos(y_pos),
    .apple_x(apple_x), .apple_y(apple_y), .snake(snake), .apple_eaten(apple_eaten),
    .game_over(game_over), .length(length)
  );

  typedef struct { int code; int eaten; int go; int len; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Game model: 0 idle, 1 play, 2 dead; directions 0 up, 1 down, 2 left, 3 right
  int m_state, m_dir, m_pend, m_cnt, m_eaten;
  int bx[$], by[$];

  function automatic void m_init();
    bx = {20, 19, 18};
    by = {15, 15, 15};
    m_dir = 3; m_pend = 3; m_cnt = 0;
  endfunction

  function automatic int opp(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int m_classify(int x, int y);
    int cx, cy;
    if (x >= 640 || y >= 480) return 0;
    cx = x / 16; cy = y / 16;
    if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
    if (bx[0] == cx && by[0] == cy) return 1;
    for (int i = 1; i < bx.size(); i++) if (bx[i] == cx && by[i] == cy) return 2;
    return 0;
  endfunction

  function automatic void m_edge();
    int old_pend, old_dir, req, hx, hy, eat, hit;
    m_eaten = 0;
    if (rst) begin m_init(); m_state = 0; return; end
    old_pend = m_pend; old_dir = m_dir;
    req = key_up ? 0 : key_down ? 1 : key_left ? 2 : key_right ? 3 : -1;
    if (req >= 0 && req != opp(old_dir)) m_pend = req;
    case (m_state)
      0: if (start) begin m_state = 1; m_cnt = 0; end
      1: if (m_cnt == STEP - 1) begin
           m_cnt = 0;
           m_dir = old_pend;
           hx = bx[0] + (old_pend == 3 ? 1 : 0) - (old_pend == 2 ? 1 : 0);
           hy = by[0] + (old_pend == 1 ? 1 : 0) - (old_pend == 0 ? 1 : 0);
           eat = (hx == int'(apple_x) && hy == int'(apple_y)) ? 1 : 0;
           hit = (hx == 0 || hx == 39 || hy == 0 || hy == 29) ? 1 : 0;
           for (int i = 0; i < bx.size(); i++)
             if ((i < bx.size() - 1 || eat == 1) && bx[i] == hx && by[i] == hy) hit = 1;
           if (hit == 1) m_state = 2;
           else begin
             bx.push_front(hx); by.push_front(hy);
             if (eat == 0 || bx.size() > MAXL) begin void'(bx.pop_back()); void'(by.pop_back()); end
             m_eaten = eat;
           end
         end else m_cnt++;
      default: if (start) begin m_init(); m_state = 1; end
    endcase
  endfunction

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("snake", int'(snake), mon_e.code);
      check("apple_eaten", int'(apple_eaten), mon_e.eaten);
      check("game_over", int'(game_over), mon_e.go);
      check("length", int'(length), mon_e.len);
    end
  end

  task automatic cyc(input int force_code = -1);
    exp_t e;
    e.code = rst ? 0 : (force_code >= 0 ? force_code : m_classify(int'(x_pos), int'(y_pos)));
    m_edge();
    e.eaten = m_eaten;
    e.go    = (m_state == 2) ? 1 : 0;
    e.len   = bx.size();
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_pix();
    int k, cx, cy;
    if ($urandom_range(0, 1) == 0) begin
      k  = $urandom_range(0, bx.size() - 1);
      cx = bx[k] + $urandom_range(0, 2) - 1;
      cy = by[k] + $urandom_range(0, 2) - 1;
      x_pos = 10'(cx * 16 + $urandom_range(0, 15));
      y_pos = 10'(cy * 16 + $urandom_range(0, 15));
    end else begin
      x_pos = 10'($urandom_range(0, 1023));
      y_pos = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic probe_px(input int x, input int y, input int code);
    x_pos = 10'(x); y_pos = 10'(y);
    cyc(code);
  endtask

  task automatic probe(input int cx, input int cy, input int code);
    probe_px(cx * 16 + 8, cy * 16 + 8, code);
  endtask

  task automatic set_apple(input int ax, input int ay);
    apple_x = 6'(ax); apple_y = 5'(ay);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    rand_pix(); cyc();
    rst = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; rand_pix(); cyc();
    start = 1'b0;
  endtask

  // k: 0 none, 1 up, 2 down, 3 left, 4 right; key held for the first cycle only
  task automatic tick(input int k);
    key_up = (k == 1); key_down = (k == 2); key_left = (k == 3); key_right = (k == 4);
    for (int n = 0; n < 2 * STEP; n++) begin
      rand_pix(); cyc();
      key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
      if (m_state != 1 || m_cnt == 0) break;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    x_pos = '0; y_pos = '0; apple_x = 6'd5; apple_y = 5'd5;
    m_init(); m_state = 0; m_eaten = 0;
    @(negedge clk);

    // Reset picture in IDLE
    do_reset(); do_reset();
    repeat (3) begin rand_pix(); cyc(); end
    probe_px(320, 240, 1); probe_px(304, 240, 2); probe_px(288, 240, 2);
    probe_px(272, 240, 0); probe_px(0, 0, 3);     probe_px(700, 10, 0);
    probe_px(100, 500, 0); probe_px(639, 479, 3); probe_px(640, 100, 0);

    // Straight run, three ticks
    press_start();
    repeat (3) tick(0);
    probe(23, 15, 1); probe(21, 15, 2); probe(20, 15, 0);
    do_reset();

    // Apple on the second tick
    set_apple(22, 15);
    press_start();
    tick(0); tick(0);
    set_apple(5, 5);
    probe(22, 15, 1); probe(19, 15, 2);
    do_reset();

    // Reverse request ignored
    press_start();
    tick(3);
    probe(21, 15, 1);
    do_reset();

    // Up then left inside one tick
    press_start();
    key_up = 1'b1; rand_pix(); cyc(); key_up = 1'b0;
    key_left = 1'b1; rand_pix(); cyc(); key_left = 1'b0;
    tick(0);
    probe(20, 14, 1); probe(20, 15, 2);
    do_reset();

    // Wall death and restart
    press_start();
    repeat (18) tick(0);
    probe(38, 15, 1);
    tick(0);
    repeat (3) begin rand_pix(); cyc(); end
    probe(38, 15, 1); probe(37, 15, 2);
    press_start();
    tick(0);
    probe(21, 15, 1);
    do_reset();

    // Grow to five, then turn into own body
    set_apple(21, 15);
    press_start();
    tick(0);
    set_apple(22, 15);
    tick(0);
    set_apple(5, 5);
    tick(2); tick(3); tick(1);
    probe(21, 16, 1);
    do_reset();

    // Tail chase in a 2x2 loop
    set_apple(21, 15);
    press_start();
    tick(0);
    set_apple(5, 5);
    repeat (3) begin tick(2); tick(3); tick(1); tick(4); end
    probe(21, 15, 1);
    do_reset();

    // Length saturation
    press_start();
    repeat (18) begin set_apple(bx[0] + 1, 15); tick(0); end
    set_apple(5, 5);
    probe(38, 15, 1);
    do_reset();

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 31);
      key_up = (r == 0 || r == 4); key_down = (r == 1);
      key_left = (r == 2 || r == 4); key_right = (r == 3);
      start = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) begin
        int ax, ay;
        ax = bx[0] + $urandom_range(0, 2) - 1;
        ay = by[0] + $urandom_range(0, 2) - 1;
        if (ax < 1) ax = 1;
        if (ax > 38) ax = 38;
        if (ay < 1) ay = 1;
        if (ay > 28) ay = 28;
        set_apple(ax, ay);
      end
      rand_pix(); cyc();
    end
    rst = 1'b0; start = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
